// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART word receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int   DATA_BITS   = 8;
    localparam int   WORD_BYTES  = 4;
    localparam logic PARITY_EVEN = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= in_i;
            sync_q <= meta_q;
        end
    end

    assign out_o = sync_q;

endmodule

// File: rtl/uart_word_rx.sv
// UART receiver: 8E1 frames are deserialized, checked, and packed
// four at a time into a 32-bit word (byte0 in the low bits).
module uart_word_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic [1:0]  byte_idx,
    output logic        busy
);

    localparam int CNT_W          = $clog2(CLKS_PER_BIT);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic rxSync;

    state_e      state_q,     state_d;
    logic [CNT_W-1:0] clkCnt_q, clkCnt_d;
    logic [2:0]  bitCnt_q,    bitCnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic        parity_q,    parity_d;
    logic [31:0] word_q,      word_d;
    logic [1:0]  byteIdx_q,   byteIdx_d;
    logic [31:0] dataOut_q,   dataOut_d;
    logic        dataValid_q, dataValid_d;
    logic        parityErr_q, parityErr_d;
    logic        frameErr_q,  frameErr_d;
    logic [TO_W-1:0] idleCnt_q, idleCnt_d;
    logic        expParity;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .in_i  (rx),
        .out_o (rxSync)
    );

    assign expParity = (^shift_q) ^ !PARITY_EVEN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clkCnt_q    <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            word_q      <= '0;
            byteIdx_q   <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            idleCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            clkCnt_q    <= clkCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            word_q      <= word_d;
            byteIdx_q   <= byteIdx_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            parityErr_q <= parityErr_d;
            frameErr_q  <= frameErr_d;
            idleCnt_q   <= idleCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clkCnt_d    = clkCnt_q + 1'b1;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        word_d      = word_q;
        byteIdx_d   = byteIdx_q;
        dataOut_d   = dataOut_q;
        dataValid_d = 1'b0;
        parityErr_d = 1'b0;
        frameErr_d  = 1'b0;
        idleCnt_d   = '0;

        unique case (state_q)
            IDLE: begin
                clkCnt_d = '0;
                if (!rxSync) begin
                    state_d  = START;
                    bitCnt_d = '0;
                end else if (byteIdx_q != 2'd0) begin
                    // A stalled partial word is abandoned after a long idle gap.
                    if (idleCnt_q == TO_LAST) begin
                        byteIdx_d = '0;
                    end else begin
                        idleCnt_d = idleCnt_q + 1'b1;
                    end
                end
            end
            START: begin
                if (clkCnt_q == HALF_BIT) begin
                    clkCnt_d = '0;
                    state_d  = rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clkCnt_q == FULL_BIT) begin
                    clkCnt_d = '0;
                    shift_d  = {rxSync, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (clkCnt_q == FULL_BIT) begin
                    clkCnt_d = '0;
                    parity_d = rxSync;
                    state_d  = STOP;
                end
            end
            STOP: begin
                // Leave at the stop mid-sample so a following start edge is not missed.
                if (clkCnt_q == FULL_BIT) begin
                    clkCnt_d = '0;
                    state_d  = IDLE;
                    if (!rxSync) begin
                        frameErr_d = 1'b1;
                        byteIdx_d  = '0;
                    end else if (parity_q != expParity) begin
                        parityErr_d = 1'b1;
                        byteIdx_d   = '0;
                    end else begin
                        word_d[{byteIdx_q, 3'b000} +: 8] = shift_q;
                        byteIdx_d = byteIdx_q + 1'b1;
                        if (byteIdx_q == 2'(WORD_BYTES - 1)) begin
                            dataOut_d   = word_d;
                            dataValid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;
    assign byte_idx   = byteIdx_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: frames are driven bit by bit and completed
// words are checked against a scoreboard queue filled when each word is sent.
module tb_uart_word_rx;

    localparam int CPB = 16;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [31:0] dataOut;
    logic        dataValid;
    logic        parityErr;
    logic        frameErr;
    logic [1:0]  byteIdx;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int validCount  = 0;
    int perrCount   = 0;
    int ferrCount   = 0;

    logic [31:0] expQ[$];

    uart_word_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (dataOut),
        .data_valid (dataValid),
        .parity_err (parityErr),
        .frame_err  (frameErr),
        .byte_idx   (byteIdx),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 8E1 frame, then two idle bit-times; parity and stop level are selectable.
    task automatic applyStimulus(input logic [7:0] b, input logic flipPar, input logic stopVal);
        logic [10:0] bits;
        bits = {stopVal, (^b) ^ flipPar, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dataValid) begin
                validCount++;
                if (expQ.size() == 0) begin
                    checkOutput("spurious_valid", 32'(dataValid), 32'h0);
                end else begin
                    checkOutput("word", dataOut, expQ.pop_front());
                end
            end
            if (parityErr) perrCount++;
            if (frameErr)  ferrCount++;
        end
    end

    initial begin
        int waited;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_data_out", dataOut, 32'h0);
        checkOutput("rst_byte_idx", 32'(byteIdx), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_pulses", {29'b0, dataValid, parityErr, frameErr}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        expQ.push_back(32'hF00F3CA5);
        applyStimulus(8'hA5, 1'b0, 1'b1);
        applyStimulus(8'h3C, 1'b0, 1'b1);
        checkOutput("w1_mid_byte_idx", 32'(byteIdx), 32'd2);
        applyStimulus(8'h0F, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        checkOutput("w1_data_out", dataOut, 32'hF00F3CA5);
        checkOutput("w1_byte_idx", 32'(byteIdx), 32'h0);
        checkOutput("w1_valid_count", 32'(validCount), 32'd1);
        checkOutput("w1_err_count", 32'(perrCount + ferrCount), 32'd0);

        applyStimulus(8'h5A, 1'b1, 1'b1);
        checkOutput("par_err_count", 32'(perrCount), 32'd1);
        checkOutput("par_byte_idx", 32'(byteIdx), 32'h0);
        expQ.push_back(32'h04030201);
        applyStimulus(8'h01, 1'b0, 1'b1);
        applyStimulus(8'h02, 1'b0, 1'b1);
        applyStimulus(8'h03, 1'b0, 1'b1);
        applyStimulus(8'h04, 1'b0, 1'b1);
        checkOutput("w2_data_out", dataOut, 32'h04030201);

        applyStimulus(8'h11, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b1);
        checkOutput("fe_pre_byte_idx", 32'(byteIdx), 32'd2);
        applyStimulus(8'h33, 1'b0, 1'b0);
        checkOutput("fe_count", 32'(ferrCount), 32'd1);
        checkOutput("fe_no_par_err", 32'(perrCount), 32'd1);
        checkOutput("fe_byte_idx", 32'(byteIdx), 32'h0);
        checkOutput("fe_data_out", dataOut, 32'h04030201);

        applyStimulus(8'h77, 1'b0, 1'b1);
        checkOutput("fs_pre_byte_idx", 32'(byteIdx), 32'd1);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("fs_busy_high", 32'(busy), 32'd1);
        rx = 1'b1;
        waited = 0;
        while (busy && waited < CPB / 2 + 3) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("fs_busy_drop", 32'(busy), 32'h0);
        checkOutput("fs_err_count", 32'(perrCount + ferrCount), 32'd2);
        checkOutput("fs_byte_idx", 32'(byteIdx), 32'd1);

        repeat (100) @(negedge clk);
        checkOutput("to_early_byte_idx", 32'(byteIdx), 32'd1);
        repeat (240) @(negedge clk);
        checkOutput("to_byte_idx", 32'(byteIdx), 32'h0);
        checkOutput("to_err_count", 32'(perrCount + ferrCount), 32'd2);
        expQ.push_back(32'h40302010);
        applyStimulus(8'h10, 1'b0, 1'b1);
        applyStimulus(8'h20, 1'b0, 1'b1);
        applyStimulus(8'h30, 1'b0, 1'b1);
        applyStimulus(8'h40, 1'b0, 1'b1);
        checkOutput("w3_data_out", dataOut, 32'h40302010);

        applyStimulus(8'hAA, 1'b0, 1'b1);
        applyStimulus(8'hBB, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        checkOutput("mid_byte_idx", 32'(byteIdx), 32'd2);
        rst = 1'b1;
        #1;
        checkOutput("arst_data_out", dataOut, 32'h0);
        checkOutput("arst_byte_idx", 32'(byteIdx), 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        checkOutput("arst_pulses", {29'b0, dataValid, parityErr, frameErr}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        expQ.push_back(32'hEFBEADDE);
        applyStimulus(8'hDE, 1'b0, 1'b1);
        applyStimulus(8'hAD, 1'b0, 1'b1);
        applyStimulus(8'hBE, 1'b0, 1'b1);
        applyStimulus(8'hEF, 1'b0, 1'b1);
        checkOutput("w4_data_out", dataOut, 32'hEFBEADDE);
        checkOutput("w4_byte_idx", 32'(byteIdx), 32'h0);

        checkOutput("final_queue_empty", 32'(expQ.size()), 32'h0);
        checkOutput("final_valid_count", 32'(validCount), 32'd4);
        checkOutput("final_perr_count", 32'(perrCount), 32'd1);
        checkOutput("final_ferr_count", 32'(ferrCount), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
